// File: rtl/core_mem_pkg.sv
// Shared types for the core memory request path: opcodes, sizes, request bundle, arbiter states.
package core_mem_pkg;

    localparam logic [2:0] COP_RD = 3'b000;
    localparam logic [2:0] COP_WR = 3'b001;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;

    typedef struct packed {
        logic [2:0]  cop;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } core_req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/core_mem_arb_wdog.sv
// Transaction watchdog: counts busy cycles without ack and flags the cycle the limit is reached.
module core_mem_arb_wdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic ack,
    output logic expire
);

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt;

    assign expire = run && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || !run || ack || expire)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/core_mem_arb.sv
// Round-robin arbiter sharing the core memory port between the I-fetch and data sides.
// state     | meaning
// ST_IDLE   | no transaction; sample both requesters and grant one
// ST_BUSY_I | I-side request driven downstream, waiting for ack or timeout
// ST_BUSY_D | D-side request driven downstream, waiting for ack or timeout
module core_mem_arb
    import core_mem_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TO_DATA        = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_val,
    input  logic [2:0]  i_req_cop,
    input  logic [2:0]  i_req_size,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        i_req_ack,
    output logic [31:0] i_req_ack_data,
    input  logic        d_req_val,
    input  logic [2:0]  d_req_cop,
    input  logic [2:0]  d_req_size,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ack,
    output logic [31:0] d_req_ack_data,
    output logic        m_req_val,
    output logic [2:0]  m_req_cop,
    output logic [2:0]  m_req_size,
    output logic [31:0] m_req_addr,
    output logic [31:0] m_req_wdata,
    input  logic        m_req_ack,
    input  logic [31:0] m_req_ack_data,
    output logic        timeout_err
);

    arb_state_e state, state_nxt;
    grant_e     last_grant;
    core_req_t  i_req, d_req, m_req_q;
    logic       busy, expire, done;

    assign i_req = {i_req_cop, i_req_size, i_req_addr, i_req_wdata};
    assign d_req = {d_req_cop, d_req_size, d_req_addr, d_req_wdata};

    assign busy = (state != ST_IDLE);
    assign done = busy && (m_req_ack || expire);

    core_mem_arb_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .run    (busy),
        .ack    (m_req_ack),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_req_val && (!d_req_val || last_grant == GRANT_D))
                    state_nxt = ST_BUSY_I;
                else if (d_req_val)
                    state_nxt = ST_BUSY_D;
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (done)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Downstream request is loaded only on the IDLE->BUSY edge, so it stays stable while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_req_q    <= '0;
            m_req_val  <= 1'b0;
            last_grant <= GRANT_D;
        end else if (state == ST_IDLE && state_nxt == ST_BUSY_I) begin
            m_req_q    <= i_req;
            m_req_val  <= 1'b1;
            last_grant <= GRANT_I;
        end else if (state == ST_IDLE && state_nxt == ST_BUSY_D) begin
            m_req_q    <= d_req;
            m_req_val  <= 1'b1;
            last_grant <= GRANT_D;
        end else if (done) begin
            m_req_val  <= 1'b0;
        end
    end

    assign m_req_cop   = m_req_q.cop;
    assign m_req_size  = m_req_q.size;
    assign m_req_addr  = m_req_q.addr;
    assign m_req_wdata = m_req_q.wdata;

    // A real ack in the expiry cycle wins over the watchdog.
    always_comb begin
        i_req_ack      = 1'b0;
        i_req_ack_data = '0;
        d_req_ack      = 1'b0;
        d_req_ack_data = '0;
        timeout_err    = expire && !m_req_ack;
        if (done) begin
            if (state == ST_BUSY_I) begin
                i_req_ack      = 1'b1;
                i_req_ack_data = m_req_ack ? m_req_ack_data : TO_DATA;
            end
            if (state == ST_BUSY_D) begin
                d_req_ack      = 1'b1;
                d_req_ack_data = m_req_ack ? m_req_ack_data : TO_DATA;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arb.sv
// Directed bench for core_mem_arb with an 8-cycle watchdog.
module tb_core_mem_arb;
    import core_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_val, d_req_val, m_req_ack;
    logic [2:0]  i_req_cop, i_req_size, d_req_cop, d_req_size;
    logic [31:0] i_req_addr, i_req_wdata, d_req_addr, d_req_wdata, m_req_ack_data;
    logic        i_req_ack, d_req_ack, m_req_val, timeout_err;
    logic [31:0] i_req_ack_data, d_req_ack_data, m_req_addr, m_req_wdata;
    logic [2:0]  m_req_cop, m_req_size;

    int total = 0;
    int bad   = 0;
    int lat;

    core_mem_arb #(.TIMEOUT_CYCLES(8), .TO_DATA(32'hDEAD_BEEF)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_val      (i_req_val),
        .i_req_cop      (i_req_cop),
        .i_req_size     (i_req_size),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .i_req_ack      (i_req_ack),
        .i_req_ack_data (i_req_ack_data),
        .d_req_val      (d_req_val),
        .d_req_cop      (d_req_cop),
        .d_req_size     (d_req_size),
        .d_req_addr     (d_req_addr),
        .d_req_wdata    (d_req_wdata),
        .d_req_ack      (d_req_ack),
        .d_req_ack_data (d_req_ack_data),
        .m_req_val      (m_req_val),
        .m_req_cop      (m_req_cop),
        .m_req_size     (m_req_size),
        .m_req_addr     (m_req_addr),
        .m_req_wdata    (m_req_wdata),
        .m_req_ack      (m_req_ack),
        .m_req_ack_data (m_req_ack_data),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic set_i(input logic v, input core_req_t r);
        i_req_val = v; i_req_cop = r.cop; i_req_size = r.size; i_req_addr = r.addr; i_req_wdata = r.wdata;
    endtask

    task automatic set_d(input logic v, input core_req_t r);
        d_req_val = v; d_req_cop = r.cop; d_req_size = r.size; d_req_addr = r.addr; d_req_wdata = r.wdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_req_val = 1'b0; d_req_val = 1'b0;
        m_req_ack = 1'b0; m_req_ack_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for the downstream request, checks it, acks on busy cycle 'delay', checks routing.
    task automatic serve(input string tag, input int delay, input logic [31:0] data,
                         input logic side_d, input core_req_t exp, input logic drop, output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!m_req_val && l < 20);
        chk({tag, "_mval"}, 32'(m_req_val), 32'd1);
        chk({tag, "_addr"}, m_req_addr, exp.addr);
        chk({tag, "_cop"}, 32'(m_req_cop), 32'(exp.cop));
        chk({tag, "_size"}, 32'(m_req_size), 32'(exp.size));
        chk({tag, "_wdata"}, m_req_wdata, exp.wdata);
        for (int k = 1; k < delay; k++) begin
            chk({tag, "_early_ack"}, 32'(side_d ? d_req_ack : i_req_ack), 32'd0);
            @(negedge clk);
        end
        m_req_ack = 1'b1;
        m_req_ack_data = data;
        #1;
        chk({tag, "_own_ack"}, 32'(side_d ? d_req_ack : i_req_ack), 32'd1);
        chk({tag, "_other_ack"}, 32'(side_d ? i_req_ack : d_req_ack), 32'd0);
        chk({tag, "_data"}, side_d ? d_req_ack_data : i_req_ack_data, data);
        chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
        @(negedge clk);
        m_req_ack = 1'b0;
        m_req_ack_data = '0;
        if (drop) begin
            if (side_d) d_req_val = 1'b0;
            else        i_req_val = 1'b0;
        end
        #1;
        chk({tag, "_gap_mval"}, 32'(m_req_val), 32'd0);
        chk({tag, "_gap_ack"}, 32'(i_req_ack | d_req_ack), 32'd0);
    endtask

    initial begin
        core_req_t ri, rd, r0;
        r0 = '0;
        rst = 1'b1;
        set_i(1'b0, r0);
        set_d(1'b0, r0);
        m_req_ack = 1'b0;
        m_req_ack_data = '0;

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_mval", 32'(m_req_val), 32'd0);
        chk("rst_maddr", m_req_addr, 32'd0);
        chk("rst_acks", 32'({i_req_ack, d_req_ack}), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_idata", i_req_ack_data, 32'd0);
        do_reset();

        // ack in IDLE is ignored
        m_req_ack = 1'b1; m_req_ack_data = 32'h5555_AAAA;
        #1;
        chk("idle_ack_i", 32'(i_req_ack), 32'd0);
        chk("idle_ack_d", 32'(d_req_ack), 32'd0);
        chk("idle_ack_data", i_req_ack_data | d_req_ack_data, 32'd0);
        m_req_ack = 1'b0; m_req_ack_data = '0;

        // I-only read
        ri = '{cop: COP_RD, size: SZ_W, addr: 32'h0000_0100, wdata: 32'h0};
        set_i(1'b1, ri);
        serve("i_only", 3, 32'h1234_5678, 1'b0, ri, 1'b1, lat);
        chk("i_only_lat", 32'(lat), 32'd1);

        // simultaneous I and D after reset: I wins the tie
        do_reset();
        rd = '{cop: COP_WR, size: SZ_W, addr: 32'h0000_0200, wdata: 32'hA5A5_A5A5};
        set_i(1'b1, ri);
        set_d(1'b1, rd);
        serve("tie_i", 2, 32'h0000_1111, 1'b0, ri, 1'b1, lat);
        chk("tie_i_lat", 32'(lat), 32'd1);
        serve("tie_d", 1, 32'h0000_2222, 1'b1, rd, 1'b1, lat);
        chk("tie_d_lat", 32'(lat), 32'd1);

        // continuous requesters alternate
        do_reset();
        ri = '{cop: COP_RD, size: SZ_H, addr: 32'h0000_0300, wdata: 32'h0};
        rd = '{cop: COP_WR, size: SZ_B, addr: 32'h0000_0400, wdata: 32'h0000_00C3};
        set_i(1'b1, ri);
        set_d(1'b1, rd);
        for (int n = 0; n < 6; n++) begin
            serve($sformatf("rr%0d", n), 1 + (n % 3), 32'hC000_0000 + 32'(n), n[0], n[0] ? rd : ri, 1'b0, lat);
            chk($sformatf("rr%0d_lat", n), 32'(lat), 32'd1);
        end
        i_req_val = 1'b0;
        d_req_val = 1'b0;

        // watchdog expiry with no ack
        do_reset();
        ri = '{cop: COP_RD, size: SZ_W, addr: 32'h0000_0500, wdata: 32'h0};
        set_i(1'b1, ri);
        @(negedge clk);
        chk("to_mval", 32'(m_req_val), 32'd1);
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("to_wait%0d", k), 32'({i_req_ack, timeout_err}), 32'd0);
            @(negedge clk);
        end
        chk("to_ack", 32'(i_req_ack), 32'd1);
        chk("to_data", i_req_ack_data, 32'hDEAD_BEEF);
        chk("to_terr", 32'(timeout_err), 32'd1);
        chk("to_dack", 32'(d_req_ack), 32'd0);
        @(negedge clk);
        i_req_val = 1'b0;
        #1;
        chk("to_after_mval", 32'(m_req_val), 32'd0);
        chk("to_after_terr", 32'(timeout_err), 32'd0);
        chk("to_after_ack", 32'(i_req_ack), 32'd0);

        // ack coincident with expiry wins
        do_reset();
        rd = '{cop: COP_RD, size: SZ_W, addr: 32'h0000_0600, wdata: 32'h0};
        set_d(1'b1, rd);
        serve("coinc", 8, 32'h0BAD_F00D, 1'b1, rd, 1'b1, lat);

        // reset during BUSY_D, then re-issue
        do_reset();
        rd = '{cop: COP_WR, size: SZ_W, addr: 32'h0000_0700, wdata: 32'h7777_0000};
        set_d(1'b1, rd);
        @(negedge clk);
        chk("mid_mval", 32'(m_req_val), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_mval", 32'(m_req_val), 32'd0);
        chk("mid_rst_dack", 32'(d_req_ack), 32'd0);
        chk("mid_rst_maddr", m_req_addr, 32'd0);
        rst = 1'b0;
        serve("mid_reissue", 2, 32'h8888_9999, 1'b1, rd, 1'b1, lat);
        chk("mid_reissue_lat", 32'(lat), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
